// File: rtl/clahe_hist_pkg.sv
// Shared state encodings and helpers for the CLAHE histogram RAM controller.
package clahe_hist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_READOUT = 3'd4
  } state_t;

  // Increment clamped to the all-ones value of a width-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/clahe_hist_fwd_unit.sv
// Read-modify-write stage for histogram accumulation: aligns reads with RAM data,
// forwards in-flight writes to cover read-during-write hazards, saturates counts.
module clahe_hist_fwd_unit
  import clahe_hist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_bin,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_bin,
  output logic [DATA_WIDTH-1:0] wr_data
);

  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_bin;
  logic                  w_valid;
  logic [ADDR_WIDTH-1:0] w_bin;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] inc;

  // S2 is the write being presented now (not yet in the RAM); W was presented
  // last cycle and committed on the same edge that sampled this read, so the
  // RAM returned the value from before it.
  always_comb begin
    base = rdata;
    if (wr_valid && (wr_bin == s1_bin)) begin
      base = wr_data;
    end else if (w_valid && (w_bin == s1_bin)) begin
      base = w_data;
    end
    inc = DATA_WIDTH'(sat_inc(32'(base), DATA_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      wr_valid <= 1'b0;
      wr_bin   <= '0;
      wr_data  <= '0;
      w_valid  <= 1'b0;
      w_bin    <= '0;
      w_data   <= '0;
    end else begin
      s1_valid <= rd_valid;
      s1_bin   <= rd_bin;
      wr_valid <= s1_valid;
      wr_bin   <= s1_bin;
      wr_data  <= inc;
      w_valid  <= wr_valid;
      w_bin    <= wr_bin;
      w_data   <= wr_data;
    end
  end

endmodule

// File: rtl/clahe_hist_ram_ctrl.sv
// CLAHE tile histogram RAM sequencer: clear, accumulate with forwarding,
// readout with optional clear-on-read, and drain.
module clahe_hist_ram_ctrl
  import clahe_hist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_clear,
  input  logic                  cmd_accum,
  input  logic                  cmd_stop,
  input  logic                  cmd_readout,
  input  logic                  rd_clear,
  input  logic                  pix_valid,
  input  logic [ADDR_WIDTH-1:0] pix_bin,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_bin,
  output logic [DATA_WIDTH-1:0] out_count,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_out
);

  localparam int unsigned NBINS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(NBINS);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  re_q, re_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  cwe_q, cwe_d;
  logic [ADDR_WIDTH-1:0] cwaddr_q, cwaddr_d;
  logic                  clr_mode_q, clr_mode_d;
  logic                  done_q, done_d;
  logic                  rd_pend_q;
  logic [ADDR_WIDTH-1:0] pend_bin_q;

  logic                  acc_rd_valid;
  logic                  fwd_we;
  logic [ADDR_WIDTH-1:0] fwd_bin;
  logic [DATA_WIDTH-1:0] fwd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      re_q       <= 1'b0;
      raddr_q    <= '0;
      cwe_q      <= 1'b0;
      cwaddr_q   <= '0;
      clr_mode_q <= 1'b0;
      done_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      pend_bin_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      re_q       <= re_d;
      raddr_q    <= raddr_d;
      cwe_q      <= cwe_d;
      cwaddr_q   <= cwaddr_d;
      clr_mode_q <= clr_mode_d;
      done_q     <= done_d;
      rd_pend_q  <= re_q && (state_q == ST_READOUT);
      pend_bin_q <= raddr_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    re_d       = 1'b0;
    raddr_d    = raddr_q;
    cwe_d      = 1'b0;
    cwaddr_d   = cwaddr_q;
    clr_mode_d = clr_mode_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_clear) begin
          state_d  = ST_CLEAR;
          cnt_d    = (ADDR_WIDTH+1)'(1);
          cwe_d    = 1'b1;
          cwaddr_d = '0;
        end else if (cmd_readout) begin
          state_d    = ST_READOUT;
          cnt_d      = (ADDR_WIDTH+1)'(1);
          re_d       = 1'b1;
          raddr_d    = '0;
          clr_mode_d = rd_clear;
        end else if (cmd_accum) begin
          state_d = ST_ACCUM;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cwe_d    = 1'b1;
          cwaddr_d = cnt_q[ADDR_WIDTH-1:0];
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_ACCUM: begin
        re_d = pix_valid;
        if (pix_valid) raddr_d = pix_bin;
        if (cmd_stop) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (cnt_q[0]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READOUT: begin
        // Zeroing write lands in the cycle the read data for that bin returns.
        cwe_d    = re_q && clr_mode_q;
        cwaddr_d = raddr_q;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          re_d    = 1'b1;
          raddr_d = cnt_q[ADDR_WIDTH-1:0];
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign acc_rd_valid = re_q && ((state_q == ST_ACCUM) || (state_q == ST_DRAIN));

  clahe_hist_fwd_unit #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fwd (
    .clk      (clk),
    .rst      (rst),
    .rd_valid (acc_rd_valid),
    .rd_bin   (raddr_q),
    .rdata    (ram_rdata),
    .wr_valid (fwd_we),
    .wr_bin   (fwd_bin),
    .wr_data  (fwd_data)
  );

  always_comb begin
    ram_we    = fwd_we | cwe_q;
    ram_waddr = fwd_we ? fwd_bin : cwaddr_q;
    ram_wdata = fwd_we ? fwd_data : '0;
  end

  assign ram_re    = re_q;
  assign ram_raddr = raddr_q;
  assign out_valid = rd_pend_q;
  assign out_bin   = pend_bin_q;
  assign out_count = rd_pend_q ? ram_rdata : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_clahe_hist_ram_ctrl.sv
// Directed bench for clahe_hist_ram_ctrl (4-bit bins, 4-bit counts) with a behavioural RAM.
module tb_clahe_hist_ram_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_clear, cmd_accum, cmd_stop, cmd_readout, rd_clear;
  logic       pix_valid;
  logic [3:0] pix_bin;
  logic [3:0] ram_raddr, ram_waddr, ram_wdata, ram_rdata;
  logic       ram_re, ram_we;
  logic       out_valid;
  logic [3:0] out_bin, out_count;
  logic       busy, done;
  logic [2:0] state_out;

  logic [3:0] mem [16];
  logic [3:0] exp_cnt [16];
  logic [3:0] pix_seq [32];
  int n_checks = 0;
  int n_pass = 0;

  clahe_hist_ram_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_clear(cmd_clear), .cmd_accum(cmd_accum), .cmd_stop(cmd_stop),
    .cmd_readout(cmd_readout), .rd_clear(rd_clear),
    .pix_valid(pix_valid), .pix_bin(pix_bin),
    .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .out_valid(out_valid), .out_bin(out_bin), .out_count(out_count),
    .busy(busy), .done(done), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple dual-port RAM, registered read, read-during-write returns old data.
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic set_exp_zero();
    for (int i = 0; i < 16; i++) exp_cnt[i] = 4'd0;
  endtask

  task automatic clear_all(input string tag);
    int writes, busy_cyc;
    bit ok_seq;
    writes = 0; busy_cyc = 0; ok_seq = 1'b1;
    // All three commands at once: clear has priority.
    cmd_clear = 1'b1; cmd_readout = 1'b1; cmd_accum = 1'b1;
    step();
    cmd_clear = 1'b0; cmd_readout = 1'b0; cmd_accum = 1'b0;
    chk({tag, "_state"}, 32'(state_out), 32'd1);
    for (int c = 0; c < 40; c++) begin
      if (done) break;
      if (busy) busy_cyc++;
      if (ram_we) begin
        if (ram_waddr !== 4'(writes) || ram_wdata !== 4'd0) ok_seq = 1'b0;
        writes++;
      end
      step();
    end
    chk({tag, "_writes"}, 32'(writes), 32'd16);
    chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd16);
    chk({tag, "_write_seq"}, 32'(ok_seq), 32'd1);
    chk({tag, "_done_idle"}, 32'({done, state_out}), 32'({1'b1, 3'd0}));
  endtask

  task automatic accum(input int len, input string tag);
    int waits;
    cmd_accum = 1'b1;
    step();
    cmd_accum = 1'b0;
    chk({tag, "_state_accum"}, 32'(state_out), 32'd2);
    for (int i = 0; i < len; i++) begin
      pix_valid = 1'b1;
      pix_bin   = pix_seq[i];
      cmd_stop  = (i == len - 1);
      step();
    end
    pix_valid = 1'b0; cmd_stop = 1'b0;
    chk({tag, "_state_drain"}, 32'(state_out), 32'd3);
    waits = 0;
    while (!done && waits < 10) begin
      step();
      waits++;
    end
    chk({tag, "_drain_len"}, 32'(waits), 32'd2);
    chk({tag, "_idle"}, 32'({busy, state_out}), 32'd0);
  endtask

  task automatic readout(input logic clr, input string tag);
    int n, done_at;
    bit gap, seen;
    n = 0; done_at = -1; gap = 1'b0; seen = 1'b0;
    cmd_readout = 1'b1; rd_clear = clr;
    step();
    cmd_readout = 1'b0; rd_clear = 1'b0;
    chk({tag, "_state"}, 32'(state_out), 32'd4);
    for (int c = 0; c < 40 && done_at < 0; c++) begin
      step();
      if (out_valid) begin
        seen = 1'b1;
        if (n < 16) begin
          chk($sformatf("%s_bin%0d", tag, n), 32'(out_bin), 32'(n));
          chk($sformatf("%s_cnt%0d", tag, n), 32'(out_count), 32'(exp_cnt[n]));
          if (clr)
            chk($sformatf("%s_clrw%0d", tag, n), 32'({ram_we, ram_waddr, ram_wdata}),
                32'({1'b1, 4'(n), 4'd0}));
        end
        if (done) done_at = n;
        n++;
      end else if (seen && done_at < 0) begin
        gap = 1'b1;
      end
    end
    chk({tag, "_words"}, 32'(n), 32'd16);
    chk({tag, "_done_at"}, 32'(done_at), 32'd15);
    chk({tag, "_no_gap"}, 32'(gap), 32'd0);
  endtask

  initial begin
    int found;
    rst = 1'b1;
    cmd_clear = 1'b0; cmd_accum = 1'b0; cmd_stop = 1'b0;
    cmd_readout = 1'b0; rd_clear = 1'b0; pix_valid = 1'b0; pix_bin = 4'd0;
    step(); step(); step();
    chk("rst_ctrl", 32'({ram_re, ram_we, out_valid, done, busy, state_out}), 32'd0);
    chk("rst_addr", 32'({ram_raddr, ram_waddr, ram_wdata}), 32'd0);
    chk("rst_out", 32'({out_bin, out_count}), 32'd0);
    rst = 1'b0;
    step();

    cmd_stop = 1'b1;
    step();
    cmd_stop = 1'b0;
    chk("stop_in_idle", 32'({busy, state_out}), 32'd0);

    // Clear then readout: all zero.
    clear_all("clr1");
    set_exp_zero();
    readout(1'b0, "ro1");

    // Back-to-back identical bins.
    for (int i = 0; i < 5; i++) pix_seq[i] = 4'd3;
    accum(5, "acc_b2b");
    set_exp_zero(); exp_cnt[3] = 4'd5;
    readout(1'b0, "ro_b2b");

    // Alternating bins exercise the W forward path.
    clear_all("clr2");
    pix_seq[0] = 4'd7; pix_seq[1] = 4'd2; pix_seq[2] = 4'd7; pix_seq[3] = 4'd2; pix_seq[4] = 4'd7;
    accum(5, "acc_alt");
    set_exp_zero(); exp_cnt[7] = 4'd3; exp_cnt[2] = 4'd2;
    readout(1'b0, "ro_alt");

    // 20 hits on a 4-bit counter saturate at 15.
    clear_all("clr3");
    for (int i = 0; i < 20; i++) pix_seq[i] = 4'd1;
    accum(20, "acc_sat");
    set_exp_zero(); exp_cnt[1] = 4'd15;
    readout(1'b0, "ro_sat");

    // Clear-on-read, then everything reads back zero.
    clear_all("clr4");
    pix_seq[0] = 4'd5; pix_seq[1] = 4'd5;
    accum(2, "acc_cor");
    set_exp_zero(); exp_cnt[5] = 4'd2;
    readout(1'b1, "ro_cor");
    set_exp_zero();
    readout(1'b0, "ro_after_cor");

    // Reset in the middle of a readout, then a fresh readout starts at bin 0.
    pix_seq[0] = 4'd9; pix_seq[1] = 4'd9;
    accum(2, "acc_rst");
    cmd_readout = 1'b1;
    step();
    cmd_readout = 1'b0;
    found = 0;
    for (int c = 0; c < 30 && found == 0; c++) begin
      step();
      if (out_valid && out_bin == 4'd6) found = 1;
    end
    chk("mid_rst_reached_bin6", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ram_we", 32'(ram_we), 32'd0);
    chk("mid_rst_state", 32'(state_out), 32'd0);
    set_exp_zero(); exp_cnt[9] = 4'd2;
    readout(1'b0, "ro_restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
